// File: rtl/conv_sched_32_8_pkg.sv
// Shared types and defaults for the 32-to-8 converter scheduler.
// Covers the FSM encoding, the lane and phase widths, and the one-hot helper.
package conv_sched_32_8_pkg;

   localparam int DEF_NUM_REQ        = 4;
   localparam int DEF_BYTES_PER_WORD = 4;
   localparam int LANE_W             = 2;
   localparam int PHASE_W            = 2;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SEND = 1'b1
   } state_t;

   function automatic logic [DEF_NUM_REQ-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
      return DEF_NUM_REQ'(1) << lane;
   endfunction

endpackage

// File: rtl/conv_sched_32_8_if.sv
// Requester word handshake plus the registered converter-side word/phase bus.
// The slave modport is the scheduler; the master modport is the requester and converter side.
interface conv_sched_32_8_if #(
   parameter int NUM_REQ = conv_sched_32_8_pkg::DEF_NUM_REQ,
   parameter int WORD_W  = 32
);
   import conv_sched_32_8_pkg::*;

   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*WORD_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_ready;
   logic [WORD_W-1:0]         data_out;
   logic                      valid_out;
   logic [PHASE_W-1:0]        phase;
   logic [LANE_W-1:0]         lane_id;

   modport master (
      output req_valid, req_data,
      input  req_ready, data_out, valid_out, phase, lane_id
   );

   modport slave (
      input  req_valid, req_data,
      output req_ready, data_out, valid_out, phase, lane_id
   );

endinterface

// File: rtl/conv_sched_32_8_rr_arbiter_4.sv
// Combinational 4-way round-robin pick: first eligible lane at or above i_rr_ptr, modulo 4.
// Zero latency. There is no backpressure; o_grant_valid is low when no lane is eligible.
module rr_arbiter_4
   import conv_sched_32_8_pkg::*;
(
   input  logic [3:0]        i_elig,
   input  logic [LANE_W-1:0] i_rr_ptr,
   output logic [LANE_W-1:0] o_grant,
   output logic              o_grant_valid
);

   logic [LANE_W-1:0] w_idx;

   // Scan from farthest to nearest, so the lane closest to the pointer wins.
   always_comb begin
      w_idx         = '0;
      o_grant       = '0;
      o_grant_valid = 1'b0;
      for (int k = 3; k >= 0; k--) begin
         w_idx = i_rr_ptr + LANE_W'(k);
         if (i_elig[w_idx]) begin
            o_grant       = w_idx;
            o_grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/conv_sched_32_8.sv
// Round-robin feed of 32-bit words into a shared 32-to-8 converter; a word accepted in cycle N is at phase 0 in N+1.
// req_ready is one-hot and is offered only when idle or at the last phase; the requester holds its word until accepted.
module conv_sched_32_8
   import conv_sched_32_8_pkg::*;
#(
   parameter int NUM_REQ        = DEF_NUM_REQ,
   parameter int WORD_W         = 32,
   parameter int BYTES_PER_WORD = DEF_BYTES_PER_WORD,
   parameter int CNT_W          = 16
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [NUM_REQ-1:0] lane_mask,
   conv_sched_32_8_if.slave   bus,
   output logic               busy,
   output logic [CNT_W-1:0]   words_sent
);

   localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(BYTES_PER_WORD - 1);

   state_t             r_state;
   state_t             w_state_nxt;
   logic [LANE_W-1:0]  r_rr_ptr;
   logic [LANE_W-1:0]  r_lane_id;
   logic [PHASE_W-1:0] r_phase;
   logic [WORD_W-1:0]  r_data;
   logic [CNT_W-1:0]   r_words;

   logic [NUM_REQ-1:0] w_elig;
   logic [NUM_REQ-1:0] w_ready;
   logic [LANE_W-1:0]  w_grant;
   logic               w_grant_vld;
   logic               w_last;
   logic               w_window;
   logic               w_accept;

   assign w_elig   = enable ? (bus.req_valid & lane_mask) : '0;
   assign w_last   = (r_state == ST_SEND) && (r_phase == LAST_PHASE);
   assign w_window = (r_state == ST_IDLE) || w_last;
   // Gating with reset keeps req_ready low for the whole reset interval.
   assign w_accept = w_window && w_grant_vld && !reset;

   rr_arbiter_4 u_arb (
      .i_elig        (w_elig),
      .i_rr_ptr      (r_rr_ptr),
      .o_grant       (w_grant),
      .o_grant_valid (w_grant_vld)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) begin
         w_state_nxt = ST_SEND;
      end else if (w_last) begin
         w_state_nxt = ST_IDLE;
      end
   end

   always_comb begin
      w_ready = '0;
      if (w_accept) begin
         w_ready = lane_onehot(w_grant);
      end
   end

   // At the last phase, an accept restarts phase 0 at once, so back-to-back words have no bubble.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_data    <= '0;
         r_lane_id <= '0;
         r_phase   <= '0;
         r_rr_ptr  <= '0;
      end else if (w_accept) begin
         r_data    <= bus.req_data[int'(w_grant) * WORD_W +: WORD_W];
         r_lane_id <= w_grant;
         r_phase   <= '0;
         r_rr_ptr  <= w_grant + LANE_W'(1);
      end else if (w_last) begin
         r_phase   <= '0;
      end else if (r_state == ST_SEND) begin
         r_phase   <= r_phase + PHASE_W'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_words <= '0;
      end else if (w_last) begin
         r_words <= r_words + CNT_W'(1);
      end
   end

   assign bus.req_ready = w_ready;
   assign bus.data_out  = r_data;
   assign bus.valid_out = (r_state == ST_SEND);
   assign bus.phase     = r_phase;
   assign bus.lane_id   = r_lane_id;
   assign busy          = (r_state == ST_SEND);
   assign words_sent    = r_words;

endmodule

// File: tb/tb_conv_sched_32_8.sv
// Scoreboard bench for conv_sched_32_8: a word-level model predicts the grants, and a monitor checks the serialized output.
// It builds two DUTs from the same stimulus: the default counter width, and a 4-bit counter to exercise wrap.
module tb_conv_sched_32_8;
   import conv_sched_32_8_pkg::*;

   localparam int WW   = 32;
   localparam int CW   = 16;
   localparam int CW_S = 4;

   typedef struct packed {
      logic [1:0]    lane;
      logic [WW-1:0] data;
   } exp_t;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            enable = 1'b0;
   logic [3:0]      lane_mask = 4'h0;
   logic [3:0]      tb_valid = 4'h0;
   logic [WW-1:0]   tb_data [4];
   logic [4*WW-1:0] tb_flat;
   logic            busy_a, busy_b;
   logic [CW-1:0]   ws_a;
   logic [CW_S-1:0] ws_b;

   exp_t            q[$];
   int              checks = 0;
   int              errors = 0;
   int              m_rem = 0;
   logic [1:0]      m_ptr = 2'd0;
   int unsigned     m_words = 0;
   int              mode = 0;
   logic [3:0]      acc = 4'h0;
   int              m_phase = 0;
   logic [WW-1:0]   last_data = '0;
   logic [1:0]      last_lane = 2'd0;

   conv_sched_32_8_if #(.NUM_REQ(4), .WORD_W(WW)) bus_a ();
   conv_sched_32_8_if #(.NUM_REQ(4), .WORD_W(WW)) bus_b ();

   always_comb tb_flat = {tb_data[3], tb_data[2], tb_data[1], tb_data[0]};
   assign bus_a.req_valid = tb_valid;
   assign bus_a.req_data  = tb_flat;
   assign bus_b.req_valid = tb_valid;
   assign bus_b.req_data  = tb_flat;

   conv_sched_32_8 #(.CNT_W(CW)) u_dut_a (
      .clk(clk), .reset(reset), .enable(enable), .lane_mask(lane_mask),
      .bus(bus_a), .busy(busy_a), .words_sent(ws_a)
   );

   conv_sched_32_8 #(.CNT_W(CW_S)) u_dut_b (
      .clk(clk), .reset(reset), .enable(enable), .lane_mask(lane_mask),
      .bus(bus_b), .busy(busy_b), .words_sent(ws_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Word-level model: a word owns the converter for 4 cycles, and the next grant may happen in its last cycle.
   task automatic model_step();
      logic [3:0] elig, exp_rdy;
      logic [1:0] g, idx;
      bit         window, found;
      exp_t       e;
      chk("words_sent", 64'(ws_a), 64'(m_words % 65536));
      chk("words_sent_cnt4", 64'(ws_b), 64'(m_words % 16));
      chk("valid_out", 64'(bus_a.valid_out), 64'(m_rem > 0));
      chk("busy", 64'(busy_a), 64'(m_rem > 0));
      chk("valid_out_cnt4", 64'(bus_b.valid_out), 64'(m_rem > 0));
      chk("busy_cnt4", 64'(busy_b), 64'(m_rem > 0));
      elig   = enable ? (tb_valid & lane_mask) : 4'h0;
      window = (m_rem <= 1);
      found  = 1'b0;
      g      = 2'd0;
      for (int k = 0; k < 4; k++) begin
         idx = m_ptr + 2'(k);
         if (!found && elig[idx]) begin
            found = 1'b1;
            g     = idx;
         end
      end
      exp_rdy = (window && found) ? (4'b0001 << g) : 4'h0;
      chk("req_ready", 64'(bus_a.req_ready), 64'(exp_rdy));
      chk("req_ready_cnt4", 64'(bus_b.req_ready), 64'(exp_rdy));
      if (m_rem == 1) m_words++;
      if (window && found) begin
         e.lane = g;
         e.data = tb_data[g];
         q.push_back(e);
         m_rem  = 4;
         m_ptr  = g + 2'd1;
         acc[g] = 1'b1;
      end else if (m_rem > 0) begin
         m_rem--;
      end
   endtask

   task automatic update_inputs();
      for (int i = 0; i < 4; i++) begin
         if (acc[i]) begin
            if (mode == 1) begin
               tb_valid[i] = 1'b0;
            end else if (mode == 2) begin
               tb_data[i]  = $urandom;
               tb_valid[i] = 1'($urandom_range(0, 1));
            end
         end else if (mode == 2) begin
            if (!tb_valid[i] && $urandom_range(0, 3) == 0) begin
               tb_data[i]  = $urandom;
               tb_valid[i] = 1'b1;
            end else if (tb_valid[i] && $urandom_range(0, 15) == 0) begin
               tb_valid[i] = 1'b0;
            end
         end
      end
      if (mode == 2) begin
         if ($urandom_range(0, 19) == 0) enable = ~enable;
         if ($urandom_range(0, 9) == 0) lane_mask = 4'($urandom);
      end
      acc = 4'h0;
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(negedge clk);
         model_step();
         @(posedge clk);
         #1;
         update_inputs();
      end
   endtask

   task automatic check_reset_outputs();
      chk("rst_valid_out", 64'(bus_a.valid_out), 64'(0));
      chk("rst_busy", 64'(busy_a), 64'(0));
      chk("rst_phase", 64'(bus_a.phase), 64'(0));
      chk("rst_lane_id", 64'(bus_a.lane_id), 64'(0));
      chk("rst_data_out", 64'(bus_a.data_out), 64'(0));
      chk("rst_req_ready", 64'(bus_a.req_ready), 64'(0));
      chk("rst_words_sent", 64'(ws_a), 64'(0));
      chk("rst_words_sent_cnt4", 64'(ws_b), 64'(0));
   endtask

   task automatic apply_reset(input int hold_cycles);
      #2 reset = 1'b1;
      #1 check_reset_outputs();
      q.delete();
      m_rem   = 0;
      m_ptr   = 2'd0;
      m_words = 0;
      acc     = 4'h0;
      repeat (hold_cycles) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   // Monitor: each valid cycle must carry the oldest outstanding word at the expected phase.
   initial begin
      forever begin
         @(negedge clk);
         if (reset) begin
            m_phase   = 0;
            last_data = '0;
            last_lane = 2'd0;
         end else if (bus_a.valid_out) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got data_out %h with nothing outstanding", bus_a.data_out);
            end else begin
               chk("data_out", 64'(bus_a.data_out), 64'(q[0].data));
               chk("data_out_cnt4", 64'(bus_b.data_out), 64'(q[0].data));
               chk("lane_id", 64'(bus_a.lane_id), 64'(q[0].lane));
               chk("lane_id_cnt4", 64'(bus_b.lane_id), 64'(q[0].lane));
               chk("phase", 64'(bus_a.phase), 64'(m_phase));
               chk("phase_cnt4", 64'(bus_b.phase), 64'(m_phase));
               last_data = q[0].data;
               last_lane = q[0].lane;
               if (m_phase == 3) begin
                  void'(q.pop_front());
                  m_phase = 0;
               end else begin
                  m_phase++;
               end
            end
         end else begin
            chk("idle_data_hold", 64'(bus_a.data_out), 64'(last_data));
            chk("idle_lane_hold", 64'(bus_a.lane_id), 64'(last_lane));
            chk("idle_phase", 64'(bus_a.phase), 64'(0));
            chk("idle_data_hold_cnt4", 64'(bus_b.data_out), 64'(last_data));
         end
      end
   end

   initial begin
      for (int i = 0; i < 4; i++) tb_data[i] = '0;
      #12 check_reset_outputs();
      @(posedge clk);
      #2 reset = 1'b0;

      // A single word on lane 2.
      #1;
      enable    = 1'b1;
      lane_mask = 4'hF;
      tb_data[2] = 32'hA1B2C3D4;
      tb_valid  = 4'b0100;
      mode      = 1;
      step(8);
      chk("t1_words_sent", 64'(ws_a), 64'(1));

      // All lanes valid from rr_ptr 0: back-to-back rotation.
      apply_reset(1);
      #1;
      for (int i = 0; i < 4; i++) tb_data[i] = {8{4'(i)}};
      tb_valid = 4'hF;
      mode     = 0;
      step(21);
      tb_valid = 4'h0;
      step(6);

      // Masked lanes 0 and 2 must never be granted.
      lane_mask = 4'b1010;
      tb_valid  = 4'hF;
      step(20);
      tb_valid = 4'h0;
      step(6);

      // Enable drops during phase 1 of the first word.
      apply_reset(1);
      #1;
      lane_mask = 4'hF;
      tb_valid  = 4'b0011;
      step(2);
      enable = 1'b0;
      step(8);
      chk("t4_words_sent", 64'(ws_a), 64'(1));
      chk("t4_idle", 64'(bus_a.valid_out), 64'(0));

      // Reset in phase 2; afterwards lanes 3 and 0 compete, starting from lane 0.
      apply_reset(1);
      #1;
      enable   = 1'b1;
      tb_valid = 4'b0011;
      step(3);
      tb_data[0] = $urandom;
      tb_data[3] = $urandom;
      tb_valid   = 4'b1001;
      apply_reset(2);
      step(12);
      tb_valid = 4'h0;
      step(6);

      // Randomized traffic; the 4-bit counter wraps many times.
      apply_reset(1);
      #1;
      enable    = 1'b1;
      lane_mask = 4'hF;
      mode      = 2;
      step(3000);

      mode     = 1;
      tb_valid = 4'h0;
      step(8);
      chk("drain_queue_empty", 64'(q.size()), 64'(0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/conv_sched_32_8.md
Name: conv_sched_32_8

Overview:
Round-robin scheduler that shares one 32-to-8 bit converter among NUM_REQ 32-bit word requesters.
- Accepts one word at a time through a valid/ready handshake.
- Holds the accepted word on the converter input for BYTES_PER_WORD cycles, with a phase index.
- Then grants the next requester with no bubble.
- Sits directly upstream of the converter in the clk4f domain. Configured by an enable and a per-lane mask.

Parameters:
NUM_REQ, 4, number of requesters (fixed to 4 for this revision; grant is 2 bits).
WORD_W, 32, requester word width.
BYTES_PER_WORD, 4, converter cycles per word (phase counts 0..3).
CNT_W, 16, width of the completed-word counter.

Ports:
clk  input  1  clock (the converter's clk4f domain); all state changes on its rising edge.
reset  input  1  asynchronous, active-high reset.
enable  input  1  1 = scheduler may accept new words; 0 = finish current word, then idle.
lane_mask  input  NUM_REQ  1 = lane eligible for grant.
req_valid  input  NUM_REQ  per-lane word available.
req_data  input  NUM_REQ*WORD_W  flattened words; lane i occupies bits [32i+31:32i].
req_ready  output  NUM_REQ  one-hot acceptance; combinational; a transfer occurs when req_valid[i] & req_ready[i].
data_out  output  WORD_W  registered word to the converter.
valid_out  output  1  registered; high while data_out holds a word being serialized.
phase  output  2  registered byte index 0..3 of the current word.
lane_id  output  2  registered source lane of the current word.
busy  output  1  registered; equals valid_out.
words_sent  output  CNT_W  registered count of completed words; wraps to 0.

Behaviour:
- Reset (asynchronous, takes effect immediately) clears:
  - state = IDLE; valid_out, busy, phase, lane_id and data_out = 0;
  - rr_ptr = 0; words_sent = 0.
  - req_ready = 0 while reset is high.
- States: IDLE, SEND.
- Accept window: the cycle is in IDLE, or in SEND with phase = 3.
- Eligible lanes: elig = req_valid & lane_mask, and only when enable = 1.
- Grant: the first set bit of elig, searching upward from rr_ptr modulo 4.
  - req_ready = one-hot(grant) only inside the accept window with elig != 0; otherwise 0.
- On accept at edge N:
  - data_out <= the granted word; lane_id <= grant; phase <= 0; valid_out <= 1; state <= SEND;
  - rr_ptr <= (grant + 1) mod 4.
- Latency: the word is accepted in cycle N; phase 0 appears in cycle N+1; phase 3 in N+4.
- SEND with phase < 3: phase increments; data_out and lane_id hold. Requester inputs are ignored.
- SEND with phase = 3:
  - words_sent increments.
  - If there is an accept: the new word starts next cycle at phase 0 (back-to-back, no idle cycle).
  - Otherwise: state <= IDLE, valid_out <= 0, phase <= 0; data_out holds its last value.
- IDLE with no accept: all outputs hold.
- Requesters must hold req_data stable while req_valid is high until accepted. Dropping req_valid before acceptance is legal; the lane simply loses eligibility.
- Changes to enable or lane_mask mid-word never affect the word in flight; they only affect the next accept window.
- Reset mid-word: the word is discarded and not counted; after release, arbitration restarts from lane 0.
- words_sent wraps from 2^CNT_W-1 to 0 with no flag.

Decomposition:
- Shared include file conv_defs.vh holds:
  - state encodings ST_IDLE = 1'b0, ST_SEND = 1'b1;
  - NUM_REQ and BYTES_PER_WORD defaults;
  - the lane-index width.
- One natural sub-module: rr_arbiter_4. It is purely combinational (inputs elig[3:0], rr_ptr[1:0]; outputs grant[1:0], grant_valid). The parent owns rr_ptr and the FSM.

Test Plan:
1. IDLE, enable = 1, lane_mask = 4'hF, req_valid = 4'b0100, lane 2 data = 32'hA1B2C3D4 -> req_ready = 4'b0100 for 1 cycle. Next 4 cycles: valid_out = 1, data_out = A1B2C3D4, lane_id = 2, phase 0,1,2,3. Then valid_out = 0 and words_sent = 1.
2. All four lanes continuously valid (data 32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333), rr_ptr = 0 -> lane_id sequence 0,1,2,3,0. valid_out stays high 20 consecutive cycles with no bubble; req_ready pulses exactly at phase 3.
3. lane_mask = 4'b1010, all lanes valid -> only lanes 1,3 alternate; req_ready[0] and req_ready[2] are never asserted.
4. Two lanes valid, enable dropped at phase 1 of the first word -> phases 2,3 complete, no further accept, IDLE, words_sent = 1.
5. reset pulsed at phase 2 -> all outputs 0 immediately and words_sent unchanged at 0. After release with lanes 3 and 0 valid, lane 0 is granted first.
6. CNT_W = 4 override, 17 words sent -> words_sent reads 15, then 0, then 1.
